fc_neuron_mac_layer: RTL and testbench
======================================

FC_NEURON_MAC_LAYER -- requirements
Module: fc_neuron_mac_layer

Interface
REQ-001 Parameters SHALL be: SIZE, default 16, data word width (signed fixed point); FRAC, default 8, fractional bits; IN_SZ, default 4, inputs per neuron; OUT_SZ, default 2, neurons in the layer.
REQ-002 Port clk SHALL be an input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit, asynchronous active-low reset.
REQ-004 Port load_value SHALL be an input, SIZE bits, the weight or bias word to store.
REQ-005 Port load_address SHALL be an input, SIZE bits, the storage slot: n*IN_SZ+i is weight(n,i); OUT_SZ*IN_SZ+n is bias(n).
REQ-006 Port load_enable SHALL be an input, 1 bit, the write strobe for load_value/load_address.
REQ-007 Port start SHALL be an input, 1 bit, a pulse that begins one layer evaluation.
REQ-008 Ports in_valid (input, 1 bit), in_data (input, SIZE bits) and in_ready (output, 1 bit) SHALL form the input-sample handshake.
REQ-009 Port busy SHALL be an output, 1 bit, high in ACCUM and FINAL.
REQ-010 Ports out_valid (output, 1 bit) and out_ack (input, 1 bit) SHALL form the result handshake.
REQ-011 Port values SHALL be an output, OUT_SZ x SIZE bits packed, with neuron 0 in the least significant slot.

Function
REQ-012 States SHALL be IDLE, ACCUM, FINAL and DONE.
REQ-013 IDLE: start=1 SHALL clear all accumulators and the sample counter and go to ACCUM.
REQ-014 ACCUM: in_ready SHALL be 1, and a sample SHALL be accepted on any edge with in_valid=1.
REQ-015 Each accepted sample i SHALL perform acc[n] += in_data*weight(n,i) for all n in parallel, as signed SIZE x SIZE products.
REQ-016 Accumulators SHALL be 2*SIZE+clog2(IN_SZ) bits wide and SHALL never overflow.
REQ-017 The sample counter SHALL increment per accepted sample; accepting sample IN_SZ-1 SHALL go to FINAL.
REQ-018 in_valid=0 SHALL stall ACCUM indefinitely with no state change.
REQ-019 FINAL (one cycle) SHALL register values[n] = sat_SIZE((acc[n] + (bias(n)<<FRAC)) >>> FRAC), using an arithmetic shift that truncates toward minus infinity, then go to DONE.
REQ-020 Saturation SHALL clamp to 'h7FFF / 'h8000 for SIZE=16, and in general to the signed SIZE-bit limits.
REQ-021 Latency: out_valid SHALL rise on the first edge after the edge that accepted the last sample.
REQ-022 DONE: out_valid SHALL be 1 and values held stable; out_ack=1 SHALL go to IDLE.
REQ-023 DONE: start=1 with out_ack=1 SHALL go directly to ACCUM with accumulators cleared.
REQ-024 DONE: start=1 without out_ack SHALL be ignored.
REQ-025 values SHALL hold their last result through IDLE and ACCUM until the next FINAL.
REQ-026 load_enable SHALL write in IDLE and DONE only, and SHALL be ignored in ACCUM and FINAL.
REQ-027 A load_address >= OUT_SZ*IN_SZ+OUT_SZ SHALL be ignored.
REQ-028 start in ACCUM or FINAL SHALL be ignored.
REQ-029 in_ready SHALL be 0 outside ACCUM, and in_valid SHALL be ignored there.

Reset
REQ-030 rst_n=0 SHALL immediately force: state IDLE; in_ready, busy and out_valid 0; values all 0; accumulators and counter 0; all weights and biases 0.
REQ-031 Reset asserted mid-ACCUM SHALL abandon the evaluation, and no out_valid SHALL follow.

Verification
REQ-032 All weights 'h0100, biases 0, inputs 'h0100,'h0200,'h0300,'h0400 -> values {'h0A00,'h0A00}, with out_valid exactly 1 edge after the 4th accept.
REQ-033 Neuron 1 weights 'hFF00 plus bias0 'h0080, same inputs -> values[0]='h0A80, values[1]='hF600.
REQ-034 All weights 'h7F00, inputs 'h7F00 -> values 'h7FFF; neuron 1 weights 'h8000 -> 'h8000 (saturation both rails).
REQ-035 in_valid toggled with 3-cycle gaps -> identical result to REQ-032; load_enable writing weight 'h0000 during ACCUM -> ignored, result unchanged.
REQ-036 rst_n pulsed after 2 accepts -> all outputs 0 at once; then reload and rerun REQ-032 -> correct.
REQ-037 Hold out_ack=0 for 5 cycles in DONE with start pulsed -> out_valid stays 1, values stable, start ignored; out_ack=1 -> IDLE next edge.

Source files
------------

// File: rtl/fc_neuron_mac_layer.sv
// Fully connected neuron layer: OUT_SZ neurons each accumulate IN_SZ signed
// fixed-point products from a streamed input vector, then add a bias,
// rescale by FRAC bits and saturate to SIZE bits.
// Weights and biases live in one small register file written through the
// load_* port. weight(n,i) is at slot n*IN_SZ+i and bias(n) is at slot
// OUT_SZ*IN_SZ+n.
module fc_neuron_mac_layer #(
  parameter int SIZE   = 16,
  parameter int FRAC   = 8,
  parameter int IN_SZ  = 4,
  parameter int OUT_SZ = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SIZE-1:0]          load_value,
  input  logic [SIZE-1:0]          load_address,
  input  logic                     load_enable,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic [SIZE-1:0]          in_data,
  output logic                     in_ready,
  output logic                     busy,
  output logic                     out_valid,
  input  logic                     out_ack,
  output logic [OUT_SZ*SIZE-1:0]   values
);

  // Accumulator is wide enough for IN_SZ worst-case products, so it can never wrap.
  localparam int ACC_W     = 2*SIZE + $clog2(IN_SZ);
  localparam int NUM_W     = OUT_SZ*IN_SZ;
  localparam int NUM_SLOTS = NUM_W + OUT_SZ;
  localparam int CNT_W     = (IN_SZ > 1) ? $clog2(IN_SZ) : 1;
  // The bias-added sum needs room for both the accumulator and bias<<FRAC, plus a carry.
  localparam int SUM_W     = ((ACC_W > SIZE+FRAC) ? ACC_W : SIZE+FRAC) + 1;

  localparam logic signed [SUM_W-1:0] SAT_MAX = {{(SUM_W-SIZE+1){1'b0}}, {(SIZE-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_MIN = {{(SUM_W-SIZE+1){1'b1}}, {(SIZE-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [SIZE-1:0]  store_q [NUM_SLOTS];
  logic signed [SIZE-1:0]  store_d [NUM_SLOTS];

  logic accept;     // a sample is consumed this cycle
  logic acc_clear;  // a new evaluation begins this cycle
  logic wr_en;      // weight/bias write allowed this cycle

  // Next-state logic, handshake outputs and control strobes.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    in_ready  = 1'b0;
    busy      = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    acc_clear = 1'b0;
    wr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        wr_en = load_enable;
        if (start) begin
          acc_clear = 1'b1;
          cnt_d     = '0;
          state_d   = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid) begin
          accept = 1'b1;
          if (cnt_q == CNT_W'(IN_SZ-1)) begin
            cnt_d   = '0;
            state_d = ST_FINAL;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_FINAL: begin
        busy    = 1'b1;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        wr_en     = load_enable;
        // start only counts when the result is acknowledged in the same cycle.
        if (out_ack) begin
          if (start) begin
            acc_clear = 1'b1;
            cnt_d     = '0;
            state_d   = ST_ACCUM;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and sample-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Weight/bias write decode; addresses past the last bias match no slot.
  always_comb begin
    store_d = store_q;
    for (int s = 0; s < NUM_SLOTS; s++) begin
      if (wr_en && (load_address == SIZE'(s))) begin
        store_d[s] = load_value;
      end
    end
  end

  // Weight/bias register file; cleared by reset so a fresh layer computes zeros.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SLOTS; s++) begin
        store_q[s] <= '0;
      end
    end else begin
      store_q <= store_d;
    end
  end

  // One MAC lane per neuron, all fed by the same input sample.
  generate
    for (genvar gi = 0; gi < OUT_SZ; gi++) begin : g_neuron
      logic signed [SIZE-1:0]   w_sel;
      logic signed [SIZE-1:0]   bias;
      logic signed [2*SIZE-1:0] prod;
      logic signed [ACC_W-1:0]  acc_q, acc_d;
      logic signed [SUM_W-1:0]  sum;
      logic signed [SUM_W-1:0]  shifted;
      logic [SIZE-1:0]          val_q, val_d;

      // Select this neuron's weight for the current sample and form the product.
      always_comb begin
        w_sel = '0;
        for (int i = 0; i < IN_SZ; i++) begin
          if (cnt_q == CNT_W'(i)) begin
            w_sel = store_q[gi*IN_SZ + i];
          end
        end
        prod = w_sel * $signed(in_data);
      end

      // Accumulate on every accepted sample; restart from zero on a new evaluation.
      always_comb begin
        acc_d = acc_q;
        if (acc_clear) begin
          acc_d = '0;
        end else if (accept) begin
          acc_d = acc_q + ACC_W'(prod);
        end
      end

      // Bias add, arithmetic rescale (floor) and clamp to the SIZE-bit signed range.
      always_comb begin
        bias    = store_q[NUM_W + gi];
        sum     = SUM_W'(acc_q) + (SUM_W'(bias) <<< FRAC);
        shifted = sum >>> FRAC;
        val_d   = val_q;
        if (state_q == ST_FINAL) begin
          if (shifted > SAT_MAX) begin
            val_d = SAT_MAX[SIZE-1:0];
          end else if (shifted < SAT_MIN) begin
            val_d = SAT_MIN[SIZE-1:0];
          end else begin
            val_d = shifted[SIZE-1:0];
          end
        end
      end

      // Accumulator and result registers; the result holds until the next FINAL.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_q <= '0;
          val_q <= '0;
        end else begin
          acc_q <= acc_d;
          val_q <= val_d;
        end
      end

      assign values[gi*SIZE +: SIZE] = val_q;
    end
  endgenerate

endmodule

// File: tb/tb_fc_neuron_mac_layer.sv
// Directed bench for fc_neuron_mac_layer with default parameters
// (SIZE=16, FRAC=8, IN_SZ=4, OUT_SZ=2). Expected results come from a
// reference model over the bench's own copy of the weights. Each result is
// pushed to a queue when the last sample is driven, and popped when out_valid
// is seen.
module tb_fc_neuron_mac_layer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] load_value = '0;
  logic [15:0] load_address = '0;
  logic        load_enable = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        busy;
  logic        out_valid;
  logic        out_ack = 1'b0;
  logic [31:0] values;

  fc_neuron_mac_layer #(.SIZE(16), .FRAC(8), .IN_SZ(4), .OUT_SZ(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_value   (load_value),
    .load_address (load_address),
    .load_enable  (load_enable),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .busy         (busy),
    .out_valid    (out_valid),
    .out_ack      (out_ack),
    .values       (values)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] exp_q[$];
  logic signed [15:0] sw[10];
  logic signed [15:0] cur_in[4];
  logic [31:0] held;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  // Reference: floor((sum x*w + bias*2^FRAC) / 2^FRAC), clamped to 16-bit signed.
  function automatic logic [31:0] model();
    logic [31:0] r;
    longint a;
    r = '0;
    for (int n = 0; n < 2; n++) begin
      a = 0;
      for (int i = 0; i < 4; i++) a += longint'(cur_in[i]) * longint'(sw[n*4+i]);
      a += longint'(sw[8+n]) * 256;
      a = a >>> 8;
      if (a > 32767)       r[n*16 +: 16] = 16'h7FFF;
      else if (a < -32768) r[n*16 +: 16] = 16'h8000;
      else                 r[n*16 +: 16] = a[15:0];
    end
    return r;
  endfunction

  task automatic load_w(input int addr, input logic [15:0] v);
    load_enable  = 1'b1;
    load_address = addr[15:0];
    load_value   = v;
    @(negedge clk);
    load_enable  = 1'b0;
    if (addr < 10) sw[addr] = v;
  endtask

  task automatic set_layer(input logic [15:0] w0, input logic [15:0] w1,
                           input logic [15:0] b0, input logic [15:0] b1);
    for (int i = 0; i < 4; i++) load_w(i, w0);
    for (int i = 0; i < 4; i++) load_w(4 + i, w1);
    load_w(8, b0);
    load_w(9, b1);
  endtask

  task automatic set_inputs(input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] c, input logic [15:0] d);
    cur_in[0] = a; cur_in[1] = b; cur_in[2] = c; cur_in[3] = d;
  endtask

  // One evaluation: optional start, 4 samples with 'gap' idle cycles before each,
  // optional ignored weight write and ignored start while accumulating.
  task automatic run_eval(input bit do_start, input int gap, input bit wr_mid, input bit start_mid);
    if (do_start) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    check("in_ready_accum", {31'd0, in_ready}, 32'd1);
    check("busy_accum", {31'd0, busy}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) exp_q.push_back(model());
      for (int g = 0; g < gap; g++) begin
        if (wr_mid && g == 0) begin
          load_enable = 1'b1; load_address = 16'd0; load_value = 16'h0000;
        end
        @(negedge clk);
        load_enable = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = cur_in[i];
      start    = start_mid && (i == 2);
      @(negedge clk);
      in_valid = 1'b0;
      start    = 1'b0;
    end
    check("final_out_valid_low", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("out_valid_latency", {31'd0, out_valid}, 32'd1);
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $error("FAIL scoreboard_empty: observed %h expected a queued result", values);
    end else begin
      check("values", values, exp_q.pop_front());
    end
    $display("result: in=%h,%h,%h,%h values=%h", cur_in[0], cur_in[1], cur_in[2], cur_in[3], values);
  endtask

  task automatic ack();
    out_ack = 1'b1;
    @(negedge clk);
    out_ack = 1'b0;
    check("idle_out_valid", {31'd0, out_valid}, 32'd0);
    check("idle_in_ready", {31'd0, in_ready}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 10; i++) sw[i] = '0;
    @(negedge clk);
    // Reset state.
    check("rst_in_ready", {31'd0, in_ready}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_values", values, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Unit weights, zero bias: 1+2+3+4 = 10.
    set_layer(16'h0100, 16'h0100, 16'h0000, 16'h0000);
    set_inputs(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    run_eval(1'b1, 0, 1'b0, 1'b0);
    check("basic_const", values, 32'h0A00_0A00);
    ack();

    // Out-of-range writes ignored; neuron 1 weights -1, bias0 +0.5.
    load_w(10, 16'h7F00);
    load_w(16, 16'h7F00);
    load_w(24, 16'h7F00);
    for (int i = 0; i < 4; i++) load_w(4 + i, 16'hFF00);
    load_w(8, 16'h0080);
    run_eval(1'b1, 0, 1'b0, 1'b0);
    check("negw_bias_const", values, 32'hF600_0A80);
    ack();

    // in_valid in IDLE ignored; stalled samples, ACCUM write and start ignored.
    set_layer(16'h0100, 16'h0100, 16'h0000, 16'h0000);
    in_valid = 1'b1;
    in_data  = 16'h7F00;
    @(negedge clk);
    check("idle_ignores_valid", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    run_eval(1'b1, 3, 1'b1, 1'b1);
    check("stall_const", values, 32'h0A00_0A00);
    ack();

    // Saturation on both rails.
    set_layer(16'h7F00, 16'h8000, 16'h0000, 16'h0000);
    set_inputs(16'h7F00, 16'h7F00, 16'h7F00, 16'h7F00);
    run_eval(1'b1, 0, 1'b0, 1'b0);
    check("sat_const", values, 32'h8000_7FFF);
    ack();

    // DONE holds with out_ack low; start alone ignored; ack returns to IDLE.
    set_layer(16'h0100, 16'h0100, 16'h0000, 16'h0000);
    set_inputs(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    run_eval(1'b1, 0, 1'b0, 1'b0);
    held  = values;
    start = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("done_hold_valid", {31'd0, out_valid}, 32'd1);
      check("done_hold_values", values, held);
      check("done_hold_in_ready", {31'd0, in_ready}, 32'd0);
    end
    start = 1'b0;
    ack();
    check("idle_values_held", values, held);

    // start with out_ack in DONE: straight to ACCUM with cleared accumulators.
    set_inputs(16'h0100, 16'h0100, 16'h0100, 16'h0100);
    run_eval(1'b1, 0, 1'b0, 1'b0);
    start   = 1'b1;
    out_ack = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    out_ack = 1'b0;
    set_inputs(16'h0100, 16'h0200, 16'h0300, 16'h0400);
    run_eval(1'b0, 0, 1'b0, 1'b0);
    check("restart_const", values, 32'h0A00_0A00);
    ack();

    // Reset after two accepts: everything clears at once, no result follows.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = cur_in[i];
      @(negedge clk);
      in_valid = 1'b0;
    end
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_values", values, 32'd0);
    for (int i = 0; i < 10; i++) sw[i] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check("postrst_no_valid", {31'd0, out_valid}, 32'd0);
    end
    // Weights were cleared by reset, so the layer computes zero.
    run_eval(1'b1, 0, 1'b0, 1'b0);
    check("cleared_weights_const", values, 32'd0);
    ack();
    set_layer(16'h0100, 16'h0100, 16'h0000, 16'h0000);
    run_eval(1'b1, 0, 1'b0, 1'b0);
    check("rerun_const", values, 32'h0A00_0A00);
    ack();

    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
